// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM capture, req/ack data-memory access with timeout,
// and MEM/WB output register. Upstream is stalled while an access is outstanding.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              stall_out,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              MemSrc_in,
  input  logic              pop_in,
  input  logic [4:0]        DestReg_in,
  input  logic [DATA_W-1:0] EX_in,
  input  logic [DATA_W-1:0] MemWrite_data_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic [4:0]        wb_DestReg,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_pop,
  output logic              mem_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             l_rw;
  logic             l_ld;
  logic             l_pop;
  logic [4:0]       l_dest;
  logic             mem_op;

  assign mem_op    = MemRead_in | MemWrite_in;
  assign stall_out = (state == WAIT);

  // The latched EX result is dmem_addr itself; it is held stable through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      l_rw        <= 1'b0;
      l_ld        <= 1'b0;
      l_pop       <= 1'b0;
      l_dest      <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_DestReg  <= '0;
      wb_data     <= '0;
      wb_pop      <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_op) begin
              wb_valid    <= 1'b1;
              wb_RegWrite <= RegWrite_in;
              wb_DestReg  <= DestReg_in;
              wb_data     <= EX_in;
              wb_pop      <= pop_in;
            end else begin
              l_rw       <= RegWrite_in;
              l_ld       <= MemToReg_in & MemRead_in & ~MemWrite_in;
              l_pop      <= pop_in;
              l_dest     <= DestReg_in;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite_in;
              dmem_addr  <= EX_in;
              dmem_wdata <= MemSrc_in ? EX_in : MemWrite_data_in;
              cnt        <= '0;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            state       <= IDLE;
            wb_valid    <= 1'b1;
            wb_RegWrite <= l_rw;
            wb_DestReg  <= l_dest;
            wb_data     <= l_ld ? dmem_rdata : dmem_addr;
            wb_pop      <= l_pop;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            dmem_req    <= 1'b0;
            mem_err     <= 1'b1;
            state       <= IDLE;
            wb_valid    <= 1'b1;
            wb_RegWrite <= 1'b0;
            wb_DestReg  <= l_dest;
            wb_data     <= dmem_addr;
            wb_pop      <= l_pop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
